dbram_req_port: RTL and testbench

- Bus-side responder that owns the data-BRAM macro's ports: one read port with 1-cycle registered read, one write port with 4-bit byte enables.
- Accepts in-order read/write requests on a valid/ready channel, drives the BRAM ports, and returns in-order responses through a small credit-limited response buffer.
- Sits between the load/store unit interconnect and the BRAM instance.

---
 rtl/dbram_req_port.sv | 208 ++++++++++++++++++++
 tb/tb_dbram_req_port.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbram_req_port.sv
// ---------------------------------------------------------------------------
// dbram_req_port
//
// Purpose:
//   Bus-side responder that owns the data-BRAM ports. Accepts in-order
//   read/write requests on a valid/ready channel, drives the BRAM read port
//   (1-cycle registered read) and the byte-enabled write port combinationally
//   in the accept cycle, and returns in-order responses through a small
//   credit-limited circular response buffer.
//
// Optional feature (compile-time macro DBRAM_ZERO_INIT_EN):
//   When defined, the INIT state sweeps every BRAM word to zero
//   (2^ADDR_W cycles) before requests are accepted. When undefined, INIT
//   lasts exactly one cycle after reset deassertion.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr              word address (ADDR_W bits)
//   req_wstrb/req_wdata   byte enables / data for writes
//   rsp_valid/rsp_ready   response handshake
//   rsp_we                echo of the request's req_we
//   rsp_rdata             read data, 0 for writes
//   ram_rd_en/addr/data   BRAM read port (data valid the cycle after enable)
//   ram_wr_en/addr/data   BRAM write port, 4 byte enables
// ---------------------------------------------------------------------------
module dbram_req_port #(
  parameter int ADDR_W    = 12,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wstrb,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [31:0]       rsp_rdata,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [31:0]       ram_rd_data,
  output logic [3:0]        ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [31:0]       ram_wr_data
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  // Wide enough to hold RSP_DEPTH + 1 so the credit arithmetic never wraps.
  localparam int CNT_W = $clog2(RSP_DEPTH + 2);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;

  // In-flight slot: the request accepted in the previous cycle.
  logic             r_if_vld;
  logic             r_if_we;

  // Circular response buffer.
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_buf_cnt;
  logic             r_buf_we    [RSP_DEPTH];
  logic [31:0]      r_buf_rdata [RSP_DEPTH];

  logic             w_acc;
  logic             w_pop;
  logic             w_buf_empty;
  logic             w_pop_buf;
  logic             w_pop_if;
  logic             w_push;
  logic [CNT_W-1:0] w_out_cnt;
  logic [CNT_W-1:0] w_credit;
  logic [31:0]      w_cap_rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Handshakes and credit
  // -------------------------------------------------------------------------
  assign w_buf_empty = (r_buf_cnt == '0);
  assign rsp_valid   = ~w_buf_empty | r_if_vld;
  assign w_pop       = rsp_valid & rsp_ready;

  // A pop this cycle frees a credit immediately, so a full buffer can still
  // accept while its head is being consumed.
  assign w_out_cnt = r_buf_cnt + CNT_W'(r_if_vld);
  assign w_credit  = w_out_cnt - CNT_W'(w_pop);
  assign req_ready = (r_state == ST_RUN) && (w_credit < CNT_W'(RSP_DEPTH));
  assign w_acc     = req_valid & req_ready;

  // With an empty buffer the in-flight entry is the head (bypass). It is
  // consumed directly when popped, otherwise it is captured into the buffer
  // because ram_rd_data is only valid for this one cycle.
  assign w_pop_buf   = w_pop & ~w_buf_empty;
  assign w_pop_if    = w_pop & w_buf_empty;
  assign w_push      = r_if_vld & ~w_pop_if;
  assign w_cap_rdata = r_if_we ? 32'h0 : ram_rd_data;

  // -------------------------------------------------------------------------
  // Response head
  // -------------------------------------------------------------------------
  always_comb begin
    rsp_we    = 1'b0;
    rsp_rdata = 32'h0;
    if (!w_buf_empty) begin
      rsp_we    = r_buf_we[r_rd_ptr];
      rsp_rdata = r_buf_rdata[r_rd_ptr];
    end else if (r_if_vld) begin
      rsp_we    = r_if_we;
      rsp_rdata = w_cap_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // BRAM ports
  // -------------------------------------------------------------------------
  assign ram_rd_en   = w_acc & ~req_we;
  assign ram_rd_addr = req_addr;

`ifdef DBRAM_ZERO_INIT_EN
  logic [ADDR_W-1:0] r_init_cnt;
  logic              w_sweep;

  // The state register sits in INIT while reset is held; gating with rst_n
  // keeps the write port quiet during reset and starts the sweep on the
  // first cycle after release.
  assign w_sweep     = (r_state == ST_INIT) & rst_n;
  assign ram_wr_en   = w_sweep ? 4'hF : ({4{w_acc & req_we}} & req_wstrb);
  assign ram_wr_addr = w_sweep ? r_init_cnt : req_addr;
  assign ram_wr_data = w_sweep ? 32'h0 : req_wdata;
`else
  assign ram_wr_en   = {4{w_acc & req_we}} & req_wstrb;
  assign ram_wr_addr = req_addr;
  assign ram_wr_data = req_wdata;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
`ifdef DBRAM_ZERO_INIT_EN
      r_init_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_INIT: begin
`ifdef DBRAM_ZERO_INIT_EN
          r_init_cnt <= r_init_cnt + ADDR_W'(1);
          if (r_init_cnt == {ADDR_W{1'b1}}) begin
            r_state <= ST_RUN;
          end
`else
          r_state <= ST_RUN;
`endif
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // In-flight slot and buffer control
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_vld  <= 1'b0;
      r_if_we   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_buf_cnt <= '0;
    end else begin
      r_if_vld <= w_acc;
      if (w_acc) begin
        r_if_we <= req_we;
      end
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_buf) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_buf_cnt <= r_buf_cnt + CNT_W'(w_push) - CNT_W'(w_pop_buf);
    end
  end

  // Buffer payload needs no reset: it is only read while r_buf_cnt != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_we[r_wr_ptr]    <= r_if_we;
      r_buf_rdata[r_wr_ptr] <= w_cap_rdata;
    end
  end

endmodule

// File: tb/tb_dbram_req_port.sv
module tb_dbram_req_port;

`ifdef DBRAM_ZERO_INIT_EN
  localparam int AW       = 4;
  localparam int INIT_CYC = 16;
`else
  localparam int AW       = 12;
  localparam int INIT_CYC = 1;
`endif
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [3:0]    req_wstrb = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_we;
  logic [31:0]   rsp_rdata;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [31:0]   ram_rd_data = '0;
  logic [3:0]    ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [31:0]   ram_wr_data;

  always #5 clk = ~clk;

  dbram_req_port #(.ADDR_W(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
  );

  // BRAM model: byte-enabled write, 1-cycle registered read.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wr_en[b]) mem[ram_wr_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] shadow [0:(1<<AW)-1];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_rsp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard checker.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      $display("rsp %0d: we=%0d rdata=%08h", n_rsp, rsp_we, rsp_rdata);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_we", 32'(rsp_we), 32'(mon_e.we));
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 once the request was accepted.
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [3:0] strb,
                      input logic [31:0] data, input logic use_exp, input logic [31:0] exp);
    int n = 0;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wstrb = strb; req_wdata = data;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", 32'(req_ready), 32'h1);
    if (req_ready) begin
      e.we = we;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) shadow[addr][8*b +: 8] = data[8*b +: 8];
        e.rdata = 32'h0;
      end else begin
        e.rdata = shadow[addr];
      end
      if (use_exp) e.rdata = exp;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 5000) begin
`ifdef DBRAM_ZERO_INIT_EN
      chk({tag, "_sweep_en"}, 32'(ram_wr_en), 32'hF);
      chk({tag, "_sweep_addr"}, 32'(ram_wr_addr), 32'(n));
`else
      chk({tag, "_init_wr_en"}, 32'(ram_wr_en), 32'h0);
`endif
      n++;
      @(negedge clk);
    end
    chk({tag, "_init_cycles"}, 32'(n), 32'(INIT_CYC));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    vec_t tbl [10];
    tbl[0] = '{1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 12'h010, 4'h0, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 12'h020, 4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[3] = '{1'b1, 12'h020, 4'h5, 32'h11223344, 32'h0};
    tbl[4] = '{1'b0, 12'h020, 4'h0, 32'h0,        32'hFF22FF44};
    tbl[5] = '{1'b1, 12'h020, 4'h0, 32'h00000000, 32'h0};
    tbl[6] = '{1'b0, 12'h020, 4'h0, 32'h0,        32'hFF22FF44};
    tbl[7] = '{1'b1, 12'h030, 4'hF, 32'h00000000, 32'h0};
    tbl[8] = '{1'b1, 12'h030, 4'hC, 32'hAABBCCDD, 32'h0};
    tbl[9] = '{1'b0, 12'h030, 4'h0, 32'h0,        32'hAABB0000};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_we", 32'(rsp_we), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ram_rd_en", 32'(ram_rd_en), 32'h0);
    chk("rst_ram_wr_en", 32'(ram_wr_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_run("boot");
    rsp_ready = 1'b1;

`ifdef DBRAM_ZERO_INIT_EN
    for (int i = 0; i < (1<<AW); i++) shadow[i] = 32'h0;
    send(1'b0, AW'(7), 4'h0, 32'h0, 1'b1, 32'h0);
    drain("zinit");
`endif

    // Table vectors, back to back (read right after write exercises the hazard).
    for (int i = 0; i < 10; i++) begin
      logic [11:0] a;
      a = tbl[i].addr;
      send(tbl[i].we, a[AW-1:0], tbl[i].strb, tbl[i].wdata, 1'b1,
           tbl[i].we ? 32'h0 : tbl[i].exp_rdata);
    end
    drain("table");

    // Full-rate streaming: fill 0..7, then 8 back-to-back reads.
    for (int i = 0; i < 8; i++)
      send(1'b1, AW'(i), 4'hF, 32'h1000_0000 | (32'(i) * 32'h0101_0101), 1'b0, 32'h0);
    drain("fill");
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i); req_wstrb = 4'h0;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        chk("stream_ready", 32'(req_ready), 32'h1);
        if (req_ready) sb.push_back('{1'b0, shadow[AW'(i)]});
      end
      if (i > 0) chk("stream_rsp_valid", 32'(rsp_valid), 32'h1);
      @(posedge clk); #1;
    end
    drain("stream");

    // Backpressure with RSP_DEPTH=2.
    send(1'b1, AW'(12'h040), 4'hF, 32'hA5A5_0040, 1'b0, 32'h0);
    send(1'b1, AW'(12'h041), 4'hF, 32'h5A5A_0041, 1'b0, 32'h0);
    send(1'b1, AW'(12'h042), 4'hF, 32'h0F0F_0042, 1'b0, 32'h0);
    drain("bp_fill");
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(12'h040);
    @(negedge clk);
    chk("bp_acc0", 32'(req_ready), 32'h1);
    sb.push_back('{1'b0, shadow[AW'(12'h040)]});
    @(posedge clk); #1;
    req_addr = AW'(12'h041);
    @(negedge clk);
    chk("bp_acc1", 32'(req_ready), 32'h1);
    sb.push_back('{1'b0, shadow[AW'(12'h041)]});
    chk("bp_hold0", rsp_rdata, shadow[AW'(12'h040)]);
    @(posedge clk); #1;
    req_addr = AW'(12'h042);
    @(negedge clk);
    chk("bp_full", 32'(req_ready), 32'h0);
    chk("bp_hold1", rsp_rdata, shadow[AW'(12'h040)]);
    chk("bp_rd_data_moved", ram_rd_data, shadow[AW'(12'h041)]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_full2", 32'(req_ready), 32'h0);
    chk("bp_hold2", rsp_rdata, shadow[AW'(12'h040)]);
    chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
    chk("bp_hold_we", 32'(rsp_we), 32'h0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(req_ready), 32'h1);
    if (req_ready) sb.push_back('{1'b0, shadow[AW'(12'h042)]});
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain("bp");

    // Reset mid-operation with two outstanding responses.
    rsp_ready = 1'b0;
    send(1'b1, AW'(12'h050), 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
    send(1'b0, AW'(12'h050), 4'h0, 32'h0, 1'b0, 32'h0);
    chk("mid_pending", 32'(rsp_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_run("post_rst");
    rsp_ready = 1'b1;
`ifdef DBRAM_ZERO_INIT_EN
    for (int i = 0; i < (1<<AW); i++) shadow[i] = 32'h0;
    send(1'b0, AW'(12'h050), 4'h0, 32'h0, 1'b1, 32'h0);
`else
    send(1'b0, AW'(12'h050), 4'h0, 32'h0, 1'b1, 32'hCAFEF00D);
`endif
    drain("post_rst");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
